member_slot_tracker: RTL and testbench

//  Upstream feeder of the priority comparator. Takes serial arrive/leave requests over a

---
 rtl/member_slot_tracker_pkg.sv | 23 ++
 rtl/member_slot_tracker_if.sv | 27 ++
 rtl/lowest_zero_enc.sv | 20 ++
 rtl/member_slot_tracker.sv | 197 +++++++++++++++++++
 tb/tb_member_slot_tracker.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/member_slot_tracker_pkg.sv
// Shared encodings and default sizing for the member slot tracker.
// Class codes, FSM states and slot geometry live here so every file agrees on them.
package member_slot_tracker_pkg;

    localparam int NP_SLOTS_DEF  = 32;
    localparam int VIP_SLOTS_DEF = 8;
    localparam int SLOT_W        = 5;
    localparam int NP_CNT_W      = 6;
    localparam int VIP_CNT_W     = 4;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'd0,
        CLS_VIP    = 2'd1,
        CLS_VVIP   = 2'd2,
        CLS_BAD    = 2'd3
    } op_class_e;

    typedef enum logic {
        IDLE = 1'b0,
        SNAP = 1'b1
    } state_e;

endpackage

// File: rtl/member_slot_tracker_if.sv
// Request, response and snapshot handshakes between a requester/comparator side
// (master) and the slot tracker (slave).
interface member_slot_tracker_if;
    import member_slot_tracker_pkg::*;

    logic              op_valid;
    logic              op_ready;
    logic              op_leave;
    logic [1:0]        op_class;
    logic [SLOT_W-1:0] op_slot;
    logic              rsp_valid;
    logic              rsp_err;
    logic [SLOT_W-1:0] rsp_slot;
    logic              snap_valid;
    logic              snap_ready;

    modport master (
        output op_valid, op_leave, op_class, op_slot, snap_ready,
        input  op_ready, rsp_valid, rsp_err, rsp_slot, snap_valid
    );

    modport slave (
        input  op_valid, op_leave, op_class, op_slot, snap_ready,
        output op_ready, rsp_valid, rsp_err, rsp_slot, snap_valid
    );

endinterface

// File: rtl/lowest_zero_enc.sv
// Finds the lowest-index clear bit of a vector; full flags that no bit is clear.
module lowest_zero_enc #(
    parameter int W  = 8,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          full
);

    // Scan from the top down so the lowest clear bit is the last one written.
    always_comb begin
        idx = {IW{1'b0}};
        for (int i = W - 1; i >= 0; i--) begin
            idx = vec[i] ? idx : IW'(i);
        end
        full = &vec;
    end

endmodule

// File: rtl/member_slot_tracker.sv
// Tracks normal/vip/vvip slot occupancy from serial arrive/leave requests and
// offers each updated set of vectors to the comparator through a snapshot handshake.
module member_slot_tracker
    import member_slot_tracker_pkg::*;
#(
    parameter int NP_SLOTS  = NP_SLOTS_DEF,
    parameter int VIP_SLOTS = VIP_SLOTS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    member_slot_tracker_if.slave bus,
    output logic [NP_SLOTS-1:0]  np,
    output logic [VIP_SLOTS-1:0] vip,
    output logic                 vvip,
    output logic [NP_CNT_W-1:0]  np_cnt,
    output logic [VIP_CNT_W-1:0] vip_cnt
);

    localparam int NP_IW  = $clog2(NP_SLOTS);
    localparam int VIP_IW = $clog2(VIP_SLOTS);

    state_e                state_r, state_nxt_s;
    logic [NP_SLOTS-1:0]   np_r, np_nxt_s;
    logic [VIP_SLOTS-1:0]  vip_r, vip_nxt_s;
    logic                  vvip_r, vvip_nxt_s;
    logic [NP_CNT_W-1:0]   np_cnt_r, np_cnt_nxt_s;
    logic [VIP_CNT_W-1:0]  vip_cnt_r, vip_cnt_nxt_s;
    logic                  op_ready_r, snap_valid_r;
    logic                  rsp_valid_r, rsp_err_r;
    logic [SLOT_W-1:0]     rsp_slot_r, slot_s;
    logic                  accept_s, err_s, upd_s;
    logic [NP_IW-1:0]      np_idx_s;
    logic [VIP_IW-1:0]     vip_idx_s;
    logic                  np_full_s, vip_full_s;

    lowest_zero_enc #(.W(NP_SLOTS)) u_np_enc (
        .vec  (np_r),
        .idx  (np_idx_s),
        .full (np_full_s)
    );

    lowest_zero_enc #(.W(VIP_SLOTS)) u_vip_enc (
        .vec  (vip_r),
        .idx  (vip_idx_s),
        .full (vip_full_s)
    );

    assign accept_s = bus.op_valid & op_ready_r;
    assign upd_s    = accept_s & ~err_s;

    // Candidate vector/count update and error decision for the request on the bus.
    always_comb begin
        np_nxt_s      = np_r;
        vip_nxt_s     = vip_r;
        vvip_nxt_s    = vvip_r;
        np_cnt_nxt_s  = np_cnt_r;
        vip_cnt_nxt_s = vip_cnt_r;
        err_s         = 1'b0;
        slot_s        = {SLOT_W{1'b0}};
        case (bus.op_class)
            CLS_NORMAL: begin
                if (bus.op_leave) begin
                    slot_s = bus.op_slot;
                    if ((int'(bus.op_slot) >= NP_SLOTS) || !np_r[bus.op_slot[NP_IW-1:0]]) begin
                        err_s = 1'b1;
                    end else begin
                        np_nxt_s[bus.op_slot[NP_IW-1:0]] = 1'b0;
                        np_cnt_nxt_s = np_cnt_r - NP_CNT_W'(1);
                    end
                end else if (np_full_s) begin
                    err_s = 1'b1;
                end else begin
                    np_nxt_s[np_idx_s] = 1'b1;
                    np_cnt_nxt_s       = np_cnt_r + NP_CNT_W'(1);
                    slot_s             = SLOT_W'(np_idx_s);
                end
            end
            CLS_VIP: begin
                if (bus.op_leave) begin
                    slot_s = bus.op_slot;
                    if ((int'(bus.op_slot) >= VIP_SLOTS) || !vip_r[bus.op_slot[VIP_IW-1:0]]) begin
                        err_s = 1'b1;
                    end else begin
                        vip_nxt_s[bus.op_slot[VIP_IW-1:0]] = 1'b0;
                        vip_cnt_nxt_s = vip_cnt_r - VIP_CNT_W'(1);
                    end
                end else if (vip_full_s) begin
                    err_s = 1'b1;
                end else begin
                    vip_nxt_s[vip_idx_s] = 1'b1;
                    vip_cnt_nxt_s        = vip_cnt_r + VIP_CNT_W'(1);
                    slot_s               = SLOT_W'(vip_idx_s);
                end
            end
            CLS_VVIP: begin
                if (bus.op_leave) begin
                    slot_s = bus.op_slot;
                    if ((bus.op_slot != {SLOT_W{1'b0}}) || !vvip_r) begin
                        err_s = 1'b1;
                    end else begin
                        vvip_nxt_s = 1'b0;
                    end
                end else if (vvip_r) begin
                    err_s = 1'b1;
                end else begin
                    vvip_nxt_s = 1'b1;
                end
            end
            default: begin
                err_s = 1'b1;
            end
        endcase
    end

    // Next-state decode: only a successful update enters SNAP.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (upd_s) begin
                    state_nxt_s = SNAP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SNAP: begin
                if (bus.snap_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SNAP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register with handshake outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            op_ready_r   <= 1'b1;
            snap_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            op_ready_r   <= (state_nxt_s == IDLE);
            snap_valid_r <= (state_nxt_s == SNAP);
        end
    end

    // Occupancy vectors and counts change only on a successful accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            np_r      <= {NP_SLOTS{1'b0}};
            vip_r     <= {VIP_SLOTS{1'b0}};
            vvip_r    <= 1'b0;
            np_cnt_r  <= {NP_CNT_W{1'b0}};
            vip_cnt_r <= {VIP_CNT_W{1'b0}};
        end else if (upd_s) begin
            np_r      <= np_nxt_s;
            vip_r     <= vip_nxt_s;
            vvip_r    <= vvip_nxt_s;
            np_cnt_r  <= np_cnt_nxt_s;
            vip_cnt_r <= vip_cnt_nxt_s;
        end
    end

    // One-cycle response pulse following each accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_slot_r  <= {SLOT_W{1'b0}};
        end else if (accept_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= err_s;
            rsp_slot_r  <= slot_s;
        end else begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_slot_r  <= {SLOT_W{1'b0}};
        end
    end

    assign bus.op_ready   = op_ready_r;
    assign bus.snap_valid = snap_valid_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_err    = rsp_err_r;
    assign bus.rsp_slot   = rsp_slot_r;
    assign np             = np_r;
    assign vip            = vip_r;
    assign vvip           = vvip_r;
    assign np_cnt         = np_cnt_r;
    assign vip_cnt        = vip_cnt_r;

endmodule

// File: tb/tb_member_slot_tracker.sv
// Directed self-checking bench for member_slot_tracker; outputs sampled on the falling edge.
module tb_member_slot_tracker;
    import member_slot_tracker_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] np;
    logic [7:0]  vip;
    logic        vvip;
    logic [5:0]  np_cnt;
    logic [3:0]  vip_cnt;
    int          checks;
    int          errors;

    member_slot_tracker_if bus ();

    member_slot_tracker dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .np      (np),
        .vip     (vip),
        .vvip    (vvip),
        .np_cnt  (np_cnt),
        .vip_cnt (vip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge where the response is visible.
    task automatic issue(input logic leave, input logic [1:0] cls, input logic [4:0] slot);
        int n = 0;
        while (bus.op_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("op_ready_wait", {31'd0, bus.op_ready}, 32'd1);
        bus.op_valid = 1'b1;
        bus.op_leave = leave;
        bus.op_class = cls;
        bus.op_slot  = slot;
        @(negedge clk);
        bus.op_valid = 1'b0;
        chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.op_valid   = 1'b0;
        bus.op_leave   = 1'b0;
        bus.op_class   = 2'd0;
        bus.op_slot    = 5'd0;
        bus.snap_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_op_ready", {31'd0, bus.op_ready}, 32'd1);
        chk("rst_snap_valid", {31'd0, bus.snap_valid}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_np", np, 32'd0);
        chk("rst_np_cnt", {26'd0, np_cnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three normal arrivals take slots 0, 1, 2
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 2'd0, 5'd0);
            chk("arr_err", {31'd0, bus.rsp_err}, 32'd0);
            chk("arr_slot", {27'd0, bus.rsp_slot}, 32'(i));
            chk("arr_snap_valid", {31'd0, bus.snap_valid}, 32'd1);
        end
        chk("arr_np", np, 32'h7);
        chk("arr_np_cnt", {26'd0, np_cnt}, 32'd3);

        // Free slot 1, then the next arrival reuses it
        issue(1'b1, 2'd0, 5'd1);
        chk("lv_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("lv_slot", {27'd0, bus.rsp_slot}, 32'd1);
        chk("lv_np", np, 32'h5);
        chk("lv_np_cnt", {26'd0, np_cnt}, 32'd2);
        issue(1'b0, 2'd0, 5'd0);
        chk("reuse_slot", {27'd0, bus.rsp_slot}, 32'd1);
        chk("reuse_np", np, 32'h7);
        chk("reuse_np_cnt", {26'd0, np_cnt}, 32'd3);

        // Fill the normal class, then one more arrival is rejected
        for (int i = 3; i < 32; i++) begin
            issue(1'b0, 2'd0, 5'd0);
            chk("fill_slot", {27'd0, bus.rsp_slot}, 32'(i));
        end
        chk("full_np", np, 32'hFFFF_FFFF);
        chk("full_np_cnt", {26'd0, np_cnt}, 32'd32);
        @(negedge clk);
        issue(1'b0, 2'd0, 5'd0);
        chk("over_err", {31'd0, bus.rsp_err}, 32'd1);
        chk("over_snap_valid", {31'd0, bus.snap_valid}, 32'd0);
        chk("over_op_ready", {31'd0, bus.op_ready}, 32'd1);
        chk("over_np", np, 32'hFFFF_FFFF);
        chk("over_np_cnt", {26'd0, np_cnt}, 32'd32);

        // VIP class allocation and reuse
        issue(1'b0, 2'd1, 5'd0);
        chk("vip0_slot", {27'd0, bus.rsp_slot}, 32'd0);
        issue(1'b0, 2'd1, 5'd0);
        chk("vip1_slot", {27'd0, bus.rsp_slot}, 32'd1);
        chk("vip_vec", {24'd0, vip}, 32'h3);
        chk("vip_cnt", {28'd0, vip_cnt}, 32'd2);
        issue(1'b1, 2'd1, 5'd0);
        chk("vip_lv_vec", {24'd0, vip}, 32'h2);
        chk("vip_lv_cnt", {28'd0, vip_cnt}, 32'd1);
        issue(1'b0, 2'd1, 5'd0);
        chk("vip_reuse_slot", {27'd0, bus.rsp_slot}, 32'd0);

        // VVIP single slot and error cases
        issue(1'b0, 2'd2, 5'd7);
        chk("vvip_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("vvip_slot", {27'd0, bus.rsp_slot}, 32'd0);
        chk("vvip_vec", {31'd0, vvip}, 32'd1);
        issue(1'b0, 2'd2, 5'd0);
        chk("vvip_dup_err", {31'd0, bus.rsp_err}, 32'd1);
        issue(1'b1, 2'd1, 5'd9);
        chk("vip_lv9_err", {31'd0, bus.rsp_err}, 32'd1);
        chk("vip_lv9_vec", {24'd0, vip}, 32'h3);
        issue(1'b0, 2'd3, 5'd0);
        chk("bad_cls_err", {31'd0, bus.rsp_err}, 32'd1);
        issue(1'b1, 2'd1, 5'd5);
        chk("vip_free_lv_err", {31'd0, bus.rsp_err}, 32'd1);
        issue(1'b1, 2'd2, 5'd1);
        chk("vvip_lv1_err", {31'd0, bus.rsp_err}, 32'd1);
        issue(1'b1, 2'd2, 5'd0);
        chk("vvip_lv_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("vvip_lv_vec", {31'd0, vvip}, 32'd0);

        // Snapshot stall: snap_ready low holds SNAP and blocks a pending request
        issue(1'b0, 2'd1, 5'd0);
        chk("stall_slot", {27'd0, bus.rsp_slot}, 32'd2);
        bus.snap_ready = 1'b0;
        bus.op_valid   = 1'b1;
        bus.op_leave   = 1'b1;
        bus.op_class   = 2'd1;
        bus.op_slot    = 5'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_snap_valid", {31'd0, bus.snap_valid}, 32'd1);
            chk("stall_op_ready", {31'd0, bus.op_ready}, 32'd0);
            chk("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            chk("stall_vip", {24'd0, vip}, 32'h7);
            chk("stall_vip_cnt", {28'd0, vip_cnt}, 32'd3);
        end
        bus.snap_ready = 1'b1;
        @(negedge clk);
        chk("release_op_ready", {31'd0, bus.op_ready}, 32'd1);
        chk("release_snap_valid", {31'd0, bus.snap_valid}, 32'd0);
        @(negedge clk);
        bus.op_valid   = 1'b0;
        bus.snap_ready = 1'b0;
        chk("pend_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("pend_rsp_slot", {27'd0, bus.rsp_slot}, 32'd0);
        chk("pend_vip", {24'd0, vip}, 32'h6);
        chk("pend_vip_cnt", {28'd0, vip_cnt}, 32'd2);

        // Reset asserted while a snapshot is pending
        @(negedge clk);
        chk("presnap_valid", {31'd0, bus.snap_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_np", np, 32'd0);
        chk("mid_rst_vip", {24'd0, vip}, 32'd0);
        chk("mid_rst_np_cnt", {26'd0, np_cnt}, 32'd0);
        chk("mid_rst_vip_cnt", {28'd0, vip_cnt}, 32'd0);
        chk("mid_rst_snap_valid", {31'd0, bus.snap_valid}, 32'd0);
        @(negedge clk);
        rst_n          = 1'b1;
        bus.snap_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_op_ready", {31'd0, bus.op_ready}, 32'd1);
        issue(1'b0, 2'd0, 5'd0);
        chk("post_rst_slot", {27'd0, bus.rsp_slot}, 32'd0);
        chk("post_rst_np", np, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
